// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - M-stage data request to split-transaction SRAM bus bridge
module data_sram_bridge #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        cancel,
  output logic        stall,
  output logic [31:0] mem_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        data_req_q, data_req_d;
  logic        data_wr_q, data_wr_d;
  logic [1:0]  data_size_q, data_size_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic        sign_q, sign_d;
  logic        drop_q, drop_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [31:0] issue_addr;
  logic [31:0] issue_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // kseg0/kseg1 fold onto the same physical window
  always_comb begin
    issue_addr = mem_addr;
    if (KSEG_MAP && (mem_addr[31:30] == 2'b10)) begin
      issue_addr = {3'b000, mem_addr[28:0]};
    end
    case (mem_size)
      2'd0:    issue_wdata = {4{mem_wdata[7:0]}};
      2'd1:    issue_wdata = {2{mem_wdata[15:0]}};
      default: issue_wdata = mem_wdata;
    endcase
  end

  always_comb begin
    case (data_addr_q[1:0])
      2'd0:    rd_byte = data_rdata[7:0];
      2'd1:    rd_byte = data_rdata[15:8];
      2'd2:    rd_byte = data_rdata[23:16];
      default: rd_byte = data_rdata[31:24];
    endcase
    rd_half = data_addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (data_size_q)
      2'd0:    load_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
      2'd1:    load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_ext = data_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_size_d  = data_size_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    sign_d       = sign_q;
    drop_d       = drop_q;
    mem_rdata_d  = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_en && !cancel) begin
          state_d      = S_REQ;
          data_req_d   = 1'b1;
          data_wr_d    = mem_wr;
          data_size_d  = mem_size;
          data_addr_d  = issue_addr;
          data_wdata_d = issue_wdata;
          sign_d       = mem_sign;
          drop_d       = 1'b0;
        end
      end
      S_REQ: begin
        if (data_addr_ok) begin
          data_req_d = 1'b0;
          if (data_data_ok) begin
            if (cancel) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DONE;
              if (!data_wr_q) mem_rdata_d = load_ext;
            end
          end else begin
            state_d = S_WAIT;
            drop_d  = cancel;
          end
        end else if (cancel) begin
          data_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        // An accepted access cannot be recalled; a flush only discards its result
        if (data_data_ok) begin
          if (drop_q || cancel) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!data_wr_q) mem_rdata_d = load_ext;
          end
        end else begin
          drop_d = drop_q | cancel;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= 32'd0;
      data_wdata_q <= 32'd0;
      sign_q       <= 1'b0;
      drop_q       <= 1'b0;
      mem_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      sign_q       <= sign_d;
      drop_q       <= drop_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign stall = rst & (((state_q == S_IDLE) & mem_en & ~cancel) |
                        (state_q == S_REQ) | (state_q == S_WAIT));
  assign mem_rdata  = mem_rdata_q;
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;

endmodule
